// File: rtl/popcount_seq.sv
// popcount_seq: multi-cycle population counter.
//
// Accepts a WIDTH-bit word on a valid/ready handshake. It counts the ones
// CHUNK bits per clock over P = ceil(WIDTH/CHUNK) cycles. It then presents
// the count and its parity on a second valid/ready handshake.
//
// Optional feature (macro POPCOUNT_ACCUM_EN): a saturating ACC_W-bit running
// total of delivered counts, with a clear input.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   in_data is valid
//   in_ready   block can accept a word (IDLE)
//   in_data    word to count, sampled only at the accept edge
//   out_valid  result valid (DONE), held until out_ready
//   out_ready  consumer takes the result
//   out_count  number of ones in the accepted word (CW bits)
//   out_parity XOR of the accepted word (= out_count[0])
//   acc_clear  [POPCOUNT_ACCUM_EN] clear running total, wins over an add
//   acc_total  [POPCOUNT_ACCUM_EN] saturating running sum of delivered counts
module popcount_seq #(
    parameter int WIDTH = 15,
    parameter int CHUNK = 7,
    parameter int ACC_W = 16,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
`ifdef POPCOUNT_ACCUM_EN
    input  logic             acc_clear,
    output logic [ACC_W-1:0] acc_total,
`endif
    output logic             out_parity
);

    localparam int P  = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int IW = (P > 1) ? $clog2(P) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Elaboration-time parameter sanity check
    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || ACC_W < 1) begin : g_bad_param
        $error("popcount_seq: illegal WIDTH/CHUNK/ACC_W");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    chunk_pc;

    // Ones in the low CHUNK bits. CHUNK <= WIDTH, so the sum fits in CW bits.
    always_comb begin
        chunk_pc = '0;
        for (int i = 0; i < CHUNK; i++)
            chunk_pc = chunk_pc + CW'(sr[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr    <= in_data;
                        cnt   <= '0;
                        idx   <= '0;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    // Zero fill means the short final chunk adds nothing extra
                    cnt <= cnt + chunk_pc;
                    sr  <= sr >> CHUNK;
                    idx <= idx + IW'(1);
                    if (idx == IW'(P - 1))
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs are decoded from state or taken straight from registers
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign out_count  = cnt;
    assign out_parity = cnt[0];

`ifdef POPCOUNT_ACCUM_EN
    localparam int SW = ((ACC_W > CW) ? ACC_W : CW) + 1;
    localparam logic [SW-1:0] ACC_MAX = SW'({ACC_W{1'b1}});

    logic [ACC_W-1:0] acc;
    logic [SW-1:0]    acc_sum;

    assign acc_sum = SW'(acc) + SW'(cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (acc_clear)
            acc <= '0;
        else if (out_valid && out_ready)
            acc <= (acc_sum > ACC_MAX) ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    end

    assign acc_total = acc;
`endif

endmodule

// File: doc/popcount_seq.md
# popcount_seq

Parametrised, multi-cycle population counter: accepts a WIDTH-bit word over a valid/ready handshake, counts its ones CHUNK bits per clock, and returns the count plus a parity flag over a second valid/ready handshake. It generalises the team's fixed 15-input combinational ones counter, which is built from 7-input and 3-input counters. Width and per-cycle chunk size are parameters, and the block has a sequential, back-pressurable datapath. It sits between a data producer and any consumer of bit-count statistics, and can optionally keep a running total.

## Interface
- WIDTH, 15: bits per input word; ≥1.
- CHUNK, 7: bits counted per clock; 1 ≤ CHUNK ≤ WIDTH.
- ACC_W, 16: accumulator width; used only with POPCOUNT_ACCUM_EN.
- Derived: CW = $clog2(WIDTH+1), the count width. P = ceil(WIDTH/CHUNK), the number of count cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  word to count.
- out_valid  out  1  out_count and out_parity are valid.
- out_ready  in  1  consumer takes the result.
- out_count  out  CW  number of ones in the accepted word.
- out_parity  out  1  XOR of the accepted word (equals out_count[0]).
- acc_clear  in  1  present only with POPCOUNT_ACCUM_EN; clears the accumulator.
- acc_total  out  ACC_W  present only with POPCOUNT_ACCUM_EN; running sum of delivered counts.

## Operation
- Reset values: state IDLE, in_ready=1, out_valid=0, out_count=0, out_parity=0, acc_total=0. The internal shift register and the chunk counter are cleared.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at a rising edge:
    - in_data is latched into the shift register;
    - the count register is cleared;
    - the chunk index is set to 0;
    - the FSM goes to COUNT.
- COUNT:
  - in_ready=0.
  - Each edge adds the popcount of shift register bits [CHUNK-1:0] to the count register, then shifts the register right by CHUNK with zero fill. Bits beyond WIDTH in the final chunk are therefore 0 and contribute nothing.
  - After the P-th addition the FSM goes to DONE.
- DONE:
  - out_valid=1. out_count and out_parity hold stable until the handshake.
  - On out_valid&out_ready the FSM goes to IDLE. There is no same-cycle re-accept: in_ready rises on the following cycle.
- Arithmetic: the count register is CW bits and can never overflow, because the maximum is WIDTH.
- in_data is sampled only at the accept edge. Changes on in_data during COUNT or DONE are ignored.
- in_valid while in_ready=0 is ignored. The producer must hold the word until it sees in_ready.
- Reset asserted in any state (including mid-COUNT or DONE with out_ready low) aborts immediately. The pending result is discarded and no out_valid pulse is issued.

## Timing
- Latency: out_valid rises exactly P cycles after the accept edge (COUNT occupies P cycles).
- With out_ready tied high, throughput is one word per P+2 cycles. For example, WIDTH=15 and CHUNK=7 give P=3 and one word per 5 cycles.
- out_valid, out_count, out_parity and in_ready are registered or decoded from state only. They have no combinational path from in_valid or out_ready.
- Backpressure: DONE persists indefinitely while out_ready=0.

## Configuration
- Macro: POPCOUNT_ACCUM_EN.
- Defined:
  - Ports acc_clear and acc_total exist.
  - On every out handshake, acc_total += out_count, saturating at 2^ACC_W-1.
  - acc_clear=1 at an edge sets acc_total to 0 and takes priority over a simultaneous add. That delivered count is lost.
  - Reset also clears acc_total.
- Undefined: neither port nor any accumulator logic exists. Counting behaviour is identical to the defined case.

## Test plan
- Reset, then WIDTH=15, CHUNK=7, in_data=15'h7FFF -> out_count=15, out_parity=1; out_valid rises 3 cycles after accept.
- in_data=15'h0000, then 15'h4001 back-to-back with out_ready=1 -> counts 0 then 2, parity 0 and 0. Accepts are spaced 5 cycles apart.
- Backpressure: in_data=15'h1234, out_ready held 0 for 6 cycles -> out_count=5 held stable, in_ready=0 throughout. Release -> one transfer, then in_ready=1 on the next cycle.
- Reset mid-operation: rst pulsed in the 2nd COUNT cycle -> all outputs return to reset values and no out_valid is seen. A subsequent word 15'h0003 yields 2.
- Non-divisible parameters: WIDTH=16, CHUNK=5 (P=4) -> 16'hFFFF yields 16, 16'h8000 yields 1, each 4 cycles after accept.
- With POPCOUNT_ACCUM_EN, ACC_W=4:
  - Frames 15'h7FFF, 15'h4001 -> acc_total=15 after the first frame and stays saturated at 15 after the second.
  - acc_clear -> acc_total=0.
  - Frame 15'h0007 -> acc_total=3.
